// File: rtl/axis_sync_fifo_1k_x8_pkg.sv
// Shared constants and width helper for the AXI4-Stream line-buffer FIFO.
// Imported by the interface, the storage RAM and the FIFO top level.
package axis_fifo_pkg;

    localparam int FIFO_DEPTH_1K = 1024;
    localparam int PIX_W         = 8;

    // Number of address bits needed to index `value` entries (value >= 2).
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_sync_fifo_1k_x8_if.sv
// AXI4-Stream beat bundle: handshake plus tdata/tlast/tuser.
// The producer side uses the master modport; the consumer side uses slave.
interface axis_sync_fifo_1k_x8_if
    import axis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = PIX_W,
    parameter int USER_WIDTH = 1
);

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tvalid, tdata, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tlast, tuser, output tready);

endinterface

// File: rtl/axis_sync_fifo_1k_x8_ram.sv
// DEPTH x WIDTH dual-port storage: synchronous write, asynchronous read,
// so the FIFO head is visible in the same cycle the read pointer moves.
module axis_fifo_ram
    import axis_fifo_pkg::*;
#(
    parameter  int WIDTH  = 10,
    parameter  int DEPTH  = FIFO_DEPTH_1K,
    localparam int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/axis_sync_fifo_1k_x8.sv
// Single-clock first-word-fall-through AXI4-Stream FIFO used as a video line buffer.
// Holds pointers, occupancy count and reset-busy flags; beats live in axis_fifo_ram.
module axis_sync_fifo_1k_x8
    import axis_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = PIX_W,
    parameter  int USER_WIDTH = 1,
    parameter  int DEPTH      = FIFO_DEPTH_1K,
    localparam int PTR_W      = clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                          s_aclk,
    input  logic                          s_areset,
    axis_sync_fifo_1k_x8_if.slave         s_axis,
    axis_sync_fifo_1k_x8_if.master        m_axis,
    output logic [CNT_W-1:0]              data_count,
    output logic                          wr_rst_busy,
    output logic                          rd_rst_busy
);

    localparam int              WORD_W     = DATA_WIDTH + 1 + USER_WIDTH;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rst_busy_q;
    logic              s_ready;
    logic              m_valid;
    logic              wr_en;
    logic              rd_en;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;

    // Both handshakes derive only from registered state, so there is no
    // combinational path between the two sides of the FIFO.
    assign s_ready = (count_q != FULL_COUNT) & ~rst_busy_q;
    assign m_valid = (count_q != '0) & ~rst_busy_q;

    assign wr_en = s_axis.tvalid & s_ready & ~s_areset;
    assign rd_en = m_valid & m_axis.tready & ~s_areset;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge s_aclk) begin
        rst_busy_q <= s_areset;
        if (s_areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_word = {s_axis.tuser, s_axis.tlast, s_axis.tdata};

    axis_fifo_ram #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (s_aclk),
        .we    (wr_en),
        .waddr (wr_ptr_q),
        .wdata (wr_word),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign {m_axis.tuser, m_axis.tlast, m_axis.tdata} = rd_word;

    assign data_count  = count_q;
    assign wr_rst_busy = rst_busy_q;
    assign rd_rst_busy = rst_busy_q;

endmodule

// File: tb/tb_axis_sync_fifo_1k_x8.sv
// Bench for the 1K x 8 AXI4-Stream FIFO: table vectors, directed corner
// sequences and random traffic checked against a queue-based reference.
module tb_axis_sync_fifo_1k_x8;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        srst;
    logic [10:0] data_count;
    logic        wr_busy;
    logic        rd_busy;

    always #5 clk = ~clk;

    axis_sync_fifo_1k_x8_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) s_if ();
    axis_sync_fifo_1k_x8_if #(.DATA_WIDTH(8), .USER_WIDTH(1)) m_if ();

    axis_sync_fifo_1k_x8 #(
        .DATA_WIDTH (8),
        .USER_WIDTH (1),
        .DEPTH      (DEPTH)
    ) dut (
        .s_aclk      (clk),
        .s_areset    (srst),
        .s_axis      (s_if),
        .m_axis      (m_if),
        .data_count  (data_count),
        .wr_rst_busy (wr_busy),
        .rd_rst_busy (rd_busy)
    );

    // Reference: an ordered queue of {tuser, tlast, tdata} words plus the busy flag.
    logic [9:0] model_q[$];
    bit         model_busy;
    int         beats_out = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    typedef struct {
        bit         s_valid;
        logic [9:0] word;
        bit         m_ready;
        bit         exp_tvalid;
        int         exp_count;
        logic [9:0] exp_head;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input logic [9:0] w, input bit r);
        s_if.tvalid = v;
        {s_if.tuser, s_if.tlast, s_if.tdata} = w;
        m_if.tready = r;
    endtask

    // Compare DUT against the reference, then advance one clock edge.
    task automatic tick();
        bit exp_tr;
        bit exp_tv;
        bit wr;
        bit rd;
        exp_tr = (model_q.size() != DEPTH) && !model_busy;
        exp_tv = (model_q.size() != 0) && !model_busy;
        chk("s_tready", s_if.tready, exp_tr);
        chk("m_tvalid", m_if.tvalid, exp_tv);
        chk("data_count", data_count, model_q.size());
        chk("wr_rst_busy", wr_busy, model_busy);
        chk("rd_rst_busy", rd_busy, model_busy);
        if (exp_tv) begin
            chk("head_beat", {m_if.tuser, m_if.tlast, m_if.tdata}, model_q[0]);
        end
        wr = s_if.tvalid && exp_tr && !srst;
        rd = m_if.tready && exp_tv && !srst;
        @(posedge clk);
        model_busy = srst;
        if (srst) begin
            model_q.delete();
        end else begin
            if (rd) begin
                void'(model_q.pop_front());
                beats_out++;
            end
            if (wr) begin
                model_q.push_back({s_if.tuser, s_if.tlast, s_if.tdata});
            end
        end
        #1;
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        drive(1'b0, 10'h0, 1'b1);
        while (model_q.size() != 0 && guard < 3000) begin
            tick();
            guard++;
        end
        tick();
        chk(name, model_q.size(), 0);
        chk({name, "_tvalid"}, m_if.tvalid, 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int start;
        int cycles;
        int pv;
        int pr;
        logic [9:0] w;

        for (int i = 0; i < 16; i++) begin
            w = {1'(i == 0), 1'(i == 15), 8'(i + 1)};
            vecs[i] = '{1'b1, w, 1'b1, 1'b1, 1, w};
        end
        vecs[16] = '{1'b0, 10'h0, 1'b1, 1'b0, 0, 10'h0};

        // Reset and release
        srst = 1'b1;
        drive(1'b0, 10'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        model_busy = 1'b1;
        model_q.delete();
        chk("rst_count", data_count, 0);
        chk("rst_tvalid", m_if.tvalid, 0);
        chk("rst_tready", s_if.tready, 0);
        chk("rst_busy", wr_busy & rd_busy, 1);
        srst = 1'b0;
        tick();
        chk("release_tready", s_if.tready, 1);

        // Table: 0x01..0x10 straight through with the consumer always ready
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].s_valid, vecs[i].word, vecs[i].m_ready);
            tick();
            chk("vec_tvalid", m_if.tvalid, vecs[i].exp_tvalid);
            chk("vec_count", data_count, vecs[i].exp_count);
            if (vecs[i].exp_tvalid) begin
                chk("vec_head", {m_if.tuser, m_if.tlast, m_if.tdata}, vecs[i].exp_head);
            end
            $display("vec %0d: in v=%0d w=%03h | out v=%0d w=%03h count=%0d",
                     i, vecs[i].s_valid, vecs[i].word, m_if.tvalid,
                     {m_if.tuser, m_if.tlast, m_if.tdata}, data_count);
        end

        // Fill to full, hold the 1025th beat, then drain in order
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, {1'b0, 1'(i == DEPTH - 1), 8'(i)}, 1'b0);
            tick();
        end
        chk("full_count", data_count, DEPTH);
        chk("full_tready", s_if.tready, 0);
        drive(1'b1, 10'h0EE, 1'b0);
        repeat (3) tick();
        chk("full_hold_count", data_count, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b0, 10'h0, 1'b1);
            chk("drain_tvalid", m_if.tvalid, 1);
            chk("drain_data", m_if.tdata, 32'(i % 256));
            tick();
        end
        chk("drained_tvalid", m_if.tvalid, 0);
        $display("fill/drain: %0d beats in order", DEPTH);

        // Full with both sides held active
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 10'($urandom), 1'b0);
            tick();
        end
        drive(1'b1, 10'($urandom), 1'b1);
        tick();
        chk("full_rd_count", data_count, DEPTH - 1);
        chk("full_rd_tready", s_if.tready, 1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 10'($urandom), 1'b1);
            tick();
        end
        drain("full_both_drain");

        // Streaming at a steady count of 5
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 10'($urandom), 1'b0);
            tick();
        end
        start = beats_out;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 10'($urandom), 1'b1);
            tick();
            chk("stream_count", data_count, 5);
            chk("stream_rate", beats_out - start, i + 1);
        end
        drain("stream_drain");

        // Random traffic against the reference queue
        start  = beats_out;
        cycles = 0;
        while ((beats_out - start) < 10000 && cycles < 60000) begin
            case ((cycles / 1500) % 4)
                0:       begin pv = 50; pr = 50; end
                1:       begin pv = 90; pr = 30; end
                2:       begin pv = 30; pr = 90; end
                default: begin pv = 75; pr = 75; end
            endcase
            drive($urandom_range(0, 99) < pv, 10'($urandom), $urandom_range(0, 99) < pr);
            tick();
            cycles++;
        end
        chk("random_beats", (beats_out - start) >= 10000, 1);
        $display("random: %0d beats out in %0d cycles", beats_out - start, cycles);
        drain("random_drain");

        // Reset with 300 entries stored, beat offered on the reset edge
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 10'($urandom), 1'b0);
            tick();
        end
        chk("pre_rst_count", data_count, 300);
        srst = 1'b1;
        drive(1'b1, 10'h3C3, 1'b1);
        tick();
        chk("mid_rst_count", data_count, 0);
        chk("mid_rst_tvalid", m_if.tvalid, 0);
        chk("mid_rst_tready", s_if.tready, 0);
        chk("mid_rst_busy", {wr_busy, rd_busy}, 2'b11);
        srst = 1'b0;
        drive(1'b0, 10'h0, 1'b0);
        tick();
        chk("post_rst_tready", s_if.tready, 1);
        chk("post_rst_busy", {wr_busy, rd_busy}, 2'b00);
        drive(1'b1, 10'h2A1, 1'b0);
        tick();
        chk("post_rst_head", {m_if.tuser, m_if.tlast, m_if.tdata}, 10'h2A1);
        drive(1'b1, 10'h152, 1'b0);
        tick();
        drain("post_rst_drain");
        $display("reset: 300 stored beats discarded, new beats delivered");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
